cmp_stream_monitor: RTL and testbench
=====================================

# cmp_stream_monitor

Downstream consumer of the 4-bit magnitude comparator's `Eq`/`Gt`/`St` result lines. It samples one comparison result per qualified clock and keeps saturating per-outcome counters. It tracks the run length of identical consecutive results and raises a sticky alarm when a run reaches a programmable threshold. It also flags malformed result codes, i.e. any sample that is not exactly one-hot.

## Interface
Parameters:
- `CNT_W`, default 8: width of each outcome counter. Range 2..16.
- `STREAK_TH`, default 4: run length that triggers the alarm. Range 2..15.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous assert and active-low.
- `clear`  input  1  synchronous clear of all state; has priority over `in_valid`.
- `in_valid`  input  1  qualifies `Eq`/`Gt`/`St` in the current cycle.
- `Eq`  input  1  comparator result A==B.
- `Gt`  input  1  comparator result A>B.
- `St`  input  1  comparator result A<B.
- `eq_cnt`  output  CNT_W  count of accepted Eq results, saturating.
- `gt_cnt`  output  CNT_W  count of accepted Gt results, saturating.
- `st_cnt`  output  CNT_W  count of accepted St results, saturating.
- `last_res`  output  2  last accepted result: 00 none, 01 Eq, 10 Gt, 11 St.
- `streak`  output  4  length of the current run of identical results; saturates at 15.
- `alarm`  output  1  sticky; high while the FSM is in ALARM.
- `err`  output  1  sticky; set when a malformed code is sampled.

## Operation
- **Sample acceptance.** A sample is taken on a rising `clk` edge when `in_valid`=1 and `clear`=0.
- **Code validity.**
  - Valid code: exactly one of `Eq`, `Gt`, `St` is 1.
  - Malformed code: 000, or two or more bits set.
- **Valid sample:**
  - The matching counter increments by 1. At 2^CNT_W-1 it holds; there is no wrap.
  - If the code equals `last_res`, `streak` becomes min(`streak`+1, 15). Otherwise `streak` becomes 1.
  - `last_res` takes the new code.
- **Malformed sample:** `err` is set to 1. Counters, `streak`, `last_res` and the FSM state are all unchanged.
- **FSM states:** IDLE, TRACK, ALARM.
  - IDLE → TRACK on the first valid sample.
  - IDLE → ALARM is impossible, because the first valid sample gives `streak`=1 and STREAK_TH≥2.
  - TRACK → ALARM when the updated `streak` ≥ STREAK_TH, evaluated on the same edge as the update.
  - ALARM holds until `clear` or reset. In ALARM, counters, `streak` and `last_res` keep updating normally.
  - Any state → IDLE on `clear`=1.
- **`alarm`** equals (state==ALARM).
- **`clear`** zeroes all counters, `streak`, `last_res` and `err`, and returns the FSM to IDLE. Any sample presented in the same cycle is discarded.
- **`in_valid`=0:** all state holds; the bus values are ignored.

## Timing
- **Reset values** (`rst_n`=0, asynchronous): every counter 0, `streak` 0, `last_res` 00, `alarm` 0, `err` 0, FSM in IDLE.
- **Reset release:** the first sample can be accepted on the first rising edge after `rst_n` goes high.
- **Reset mid-run:** asserting `rst_n` clears all state immediately, without waiting for a clock edge.
- **Latency:** all outputs are registered. The effect of a sample is visible one cycle after the accepting edge, so a sample taken at edge N is reflected in the outputs after edge N.
- **Throughput:** one sample per cycle. There is no backpressure and no ready signal.
- **Simultaneous `clear` and `in_valid`:** `clear` wins and the sample is lost.
- **Saturation boundaries:**
  - A counter at its maximum stays there. Other counters still increment.
  - `streak` at 15 stays at 15 while the result repeats.
  - A different result reloads `streak` to 1, but the FSM stays in ALARM.
- **`err` independence:** `err` does not affect `alarm`. Both may be high at once.

## Test plan
- **Reset and idle.** Assert `rst_n`=0 mid-simulation, then release. Required: every output is 0 and `last_res`=00. Then hold `in_valid`=0 with `Eq`/`Gt`/`St` = 1/0/0 for 5 cycles. Required: nothing changes.
- **Basic counting.** Defaults (CNT_W=8, STREAK_TH=4). Feed Eq, Gt, Gt, St. Required: `eq_cnt`=1, `gt_cnt`=2, `st_cnt`=1, `last_res`=11, `streak`=1, `alarm`=0.
- **Alarm trigger.**
  - Feed Gt four times back to back. Required: `streak` steps 1, 2, 3, 4, and `alarm` rises one cycle after the 4th accepting edge.
  - Then feed one St. Required: `streak`=1 and `alarm` stays 1.
  - Then pulse `clear`. Required: all outputs return to 0.
- **Malformed codes.**
  - Feed code 110, then 000. Required: `err`=1 and all counters, `streak` and `last_res` unchanged.
  - Then feed a valid Eq. Required: `eq_cnt` increments and `err` stays 1.
- **Saturation.** CNT_W=2. Feed Eq 20 times. Required: `eq_cnt` holds at 3, `streak` holds at 15, `alarm`=1, and no other counter moves.
- **Clear priority.** Drive `clear`=1 and `in_valid`=1 with Gt in the same cycle, starting from `gt_cnt`=5. Required: `gt_cnt`=0, FSM in IDLE, `last_res`=00.

Source files
------------

// File: rtl/cmp_stream_monitor.sv
// cmp_stream_monitor: samples Eq/Gt/St comparator results, keeps saturating
// per-outcome counters, tracks identical-result runs with a sticky alarm FSM,
// and flags malformed (non one-hot) result codes.

// Saturating up-counter, one instance per outcome.
module cmp_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // Count accepted hits; hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end
endmodule

module cmp_stream_monitor #(
  parameter int CNT_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             Eq,
  input  logic             Gt,
  input  logic             St,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] st_cnt,
  output logic [1:0]       last_res,
  output logic [3:0]       streak,
  output logic             alarm,
  output logic             err
);
  localparam int NUM_OUT = 3;

  typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      code_c;
  logic                            onehot_c;
  logic                            acc_c, vsamp_c, bad_c;
  logic [3:0]                      streak_nxt;
  logic [NUM_OUT-1:0]              inc_c;
  logic [NUM_OUT-1:0][CNT_W-1:0]   cnt_q;

  // Decode the result bus into the last_res encoding; anything not one-hot
  // is malformed.
  always_comb begin
    code_c   = 2'b00;
    onehot_c = 1'b1;
    case ({Eq, Gt, St})
      3'b100:  code_c = 2'b01;
      3'b010:  code_c = 2'b10;
      3'b001:  code_c = 2'b11;
      default: onehot_c = 1'b0;
    endcase
  end

  // clear discards any sample offered in the same cycle.
  assign acc_c   = in_valid && !clear;
  assign vsamp_c = acc_c && onehot_c;
  assign bad_c   = acc_c && !onehot_c;

  // Run length after this sample: extend on repeat (capped at 15), else restart.
  always_comb begin
    streak_nxt = 4'd1;
    if (code_c == last_res)
      streak_nxt = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
  end

  // One saturating counter per outcome; lane i counts code i+1.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    assign inc_c[i] = vsamp_c && (code_c == 2'(i + 1));
    cmp_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc_c[i]),
      .cnt   (cnt_q[i])
    );
  end

  assign eq_cnt = cnt_q[0];
  assign gt_cnt = cnt_q[1];
  assign st_cnt = cnt_q[2];

  // Run tracking and last result; malformed samples leave these untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak   <= 4'd0;
      last_res <= 2'b00;
    end else if (clear) begin
      streak   <= 4'd0;
      last_res <= 2'b00;
    end else if (vsamp_c) begin
      streak   <= streak_nxt;
      last_res <= code_c;
    end
  end

  // Sticky malformed-code flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err <= 1'b0;
    else if (clear) err <= 1'b0;
    else if (bad_c) err <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: alarm is judged on the post-update run length of the same edge.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (vsamp_c) begin
      case (state_q)
        IDLE:    state_d = TRACK;
        TRACK:   if (32'(streak_nxt) >= STREAK_TH) state_d = ALARM;
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  assign alarm = (state_q == ALARM);

endmodule

// File: tb/tb_cmp_stream_monitor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops one per cycle, #1 after the rising edge, and compares.
module tb_cmp_stream_monitor;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic Eq = 1'b0, Gt = 1'b0, St = 1'b0;

  logic [7:0] eq8, gt8, st8;
  logic [1:0] eq2, gt2, st2;
  logic [1:0] last8, last2;
  logic [3:0] stk8, stk2;
  logic       alm8, alm2, err8, err2;

  always #5 clk = ~clk;

  cmp_stream_monitor #(.CNT_W(8), .STREAK_TH(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .Eq(Eq), .Gt(Gt), .St(St),
    .eq_cnt(eq8), .gt_cnt(gt8), .st_cnt(st8),
    .last_res(last8), .streak(stk8), .alarm(alm8), .err(err8));

  cmp_stream_monitor #(.CNT_W(2), .STREAK_TH(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .Eq(Eq), .Gt(Gt), .St(St),
    .eq_cnt(eq2), .gt_cnt(gt2), .st_cnt(st2),
    .last_res(last2), .streak(stk2), .alarm(alm2), .err(err2));

  typedef struct {
    string      name;
    bit         sel2;    // 1: check the CNT_W=2 instance
    logic [7:0] eq, gt, st;
    logic [1:0] last;
    logic [3:0] stk;
    logic       alm, err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Monitor: one expectation per cycle, sampled away from the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] a_eq, a_gt, a_st;
      logic [1:0] a_last;
      logic [3:0] a_stk;
      logic       a_alm, a_err;
      e = q.pop_front();
      if (e.sel2) begin
        a_eq = {6'd0, eq2}; a_gt = {6'd0, gt2}; a_st = {6'd0, st2};
        a_last = last2; a_stk = stk2; a_alm = alm2; a_err = err2;
      end else begin
        a_eq = eq8; a_gt = gt8; a_st = st8;
        a_last = last8; a_stk = stk8; a_alm = alm8; a_err = err8;
      end
      n_chk++;
      if (a_eq !== e.eq || a_gt !== e.gt || a_st !== e.st || a_last !== e.last ||
          a_stk !== e.stk || a_alm !== e.alm || a_err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got eq=%0d gt=%0d st=%0d last=%b streak=%0d alarm=%b err=%b, want eq=%0d gt=%0d st=%0d last=%b streak=%0d alarm=%b err=%b",
                 e.name, a_eq, a_gt, a_st, a_last, a_stk, a_alm, a_err,
                 e.eq, e.gt, e.st, e.last, e.stk, e.alm, e.err);
      end
    end
  end

  // Drive one cycle of inputs on the falling edge.
  task automatic drv(input logic v, input logic [2:0] code, input logic c);
    @(negedge clk);
    in_valid = v; {Eq, Gt, St} = code; clear = c;
  endtask

  task automatic expect_(input string nm, input bit s2,
                         input int ee, input int eg, input int es,
                         input logic [1:0] l, input int k,
                         input logic a, input logic r);
    exp_t e;
    e.name = nm; e.sel2 = s2;
    e.eq = 8'(ee); e.gt = 8'(eg); e.st = 8'(es);
    e.last = l; e.stk = 4'(k); e.alm = a; e.err = r;
    q.push_back(e);
  endtask

  localparam logic [2:0] C_EQ = 3'b100, C_GT = 3'b010, C_ST = 3'b001;

  initial begin
    int wait_cyc;
    // Reset state
    drv(0, 3'b000, 0); expect_("reset", 0, 0,0,0, 2'b00, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    // Idle with a valid-looking bus: nothing moves
    for (int i = 0; i < 5; i++) begin
      drv(0, C_EQ, 0); expect_("idle_hold", 0, 0,0,0, 2'b00, 0, 0, 0);
    end
    // Basic counting
    drv(1, C_EQ, 0); expect_("basic_eq",  0, 1,0,0, 2'b01, 1, 0, 0);
    drv(1, C_GT, 0); expect_("basic_gt1", 0, 1,1,0, 2'b10, 1, 0, 0);
    drv(1, C_GT, 0); expect_("basic_gt2", 0, 1,2,0, 2'b10, 2, 0, 0);
    drv(1, C_ST, 0); expect_("basic_st",  0, 1,2,1, 2'b11, 1, 0, 0);
    // Alarm trigger on 4th consecutive Gt
    drv(1, C_GT, 0); expect_("run1", 0, 1,3,1, 2'b10, 1, 0, 0);
    drv(1, C_GT, 0); expect_("run2", 0, 1,4,1, 2'b10, 2, 0, 0);
    drv(1, C_GT, 0); expect_("run3", 0, 1,5,1, 2'b10, 3, 0, 0);
    drv(1, C_GT, 0); expect_("run4_alarm", 0, 1,6,1, 2'b10, 4, 1, 0);
    drv(1, C_ST, 0); expect_("alarm_sticky", 0, 1,6,2, 2'b11, 1, 1, 0);
    drv(0, C_ST, 1); expect_("clear_all", 0, 0,0,0, 2'b00, 0, 0, 0);
    // Malformed codes
    drv(1, 3'b110, 0); expect_("bad_110", 0, 0,0,0, 2'b00, 0, 0, 1);
    drv(1, 3'b000, 0); expect_("bad_000", 0, 0,0,0, 2'b00, 0, 0, 1);
    drv(1, C_EQ, 0);   expect_("eq_after_bad", 0, 1,0,0, 2'b01, 1, 0, 1);
    drv(1, 3'b111, 0); expect_("bad_111", 0, 1,0,0, 2'b01, 1, 0, 1);
    // Reset mid-run
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b1; {Eq, Gt, St} = C_EQ;
    expect_("midrun_reset", 0, 0,0,0, 2'b00, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    // Clear priority from gt_cnt=5 (alarm already up)
    for (int i = 1; i <= 5; i++) begin
      drv(1, C_GT, 0); expect_("pre_clear_gt", 0, 0,i,0, 2'b10, i, (i >= 4), 0);
    end
    drv(1, C_GT, 1); expect_("clear_priority", 0, 0,0,0, 2'b00, 0, 0, 0);
    drv(1, C_GT, 0); expect_("after_clear_idle", 0, 0,1,0, 2'b10, 1, 0, 0);
    // Saturation on the CNT_W=2 instance
    drv(0, 3'b000, 1); expect_("sat_clear", 1, 0,0,0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      drv(1, C_EQ, 0);
      expect_("sat_eq", 1, (i < 3) ? i : 3, 0, 0, 2'b01, (i < 15) ? i : 15, (i >= 4), 0);
    end
    drv(1, C_GT, 0); expect_("sat_other_inc", 1, 3,1,0, 2'b10, 1, 1, 0);
    drv(0, 3'b000, 0);
    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 50) begin
      @(negedge clk); wait_cyc++;
    end
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
